uart_tx_controller: RTL and testbench

UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_counter.sv | 29 ++
 rtl/uart_tx_controller.sv | 117 +++++++++++
 tb/tb_uart_tx_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmit types: controller state encoding and line-source select codes.
// Combinational definitions only: no latency, no backpressure.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic [1:0] UART_SEL_IDLE   = 2'd0;
  localparam logic [1:0] UART_SEL_START  = 2'd1;
  localparam logic [1:0] UART_SEL_DATA   = 2'd2;
  localparam logic [1:0] UART_SEL_PARITY = 2'd3;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, bit_tick on the last count; latency 0 (tick is combinational).
// No backpressure: free-running unless clear is held, which parks the count at 0.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_controller.sv
// UART frame sequencer (START, LSB-first DATA, optional PARITY under UART_TX_PARITY_EN, STOP); START entered 1 cycle after accept.
// Backpressure: tx_ready only in IDLE; tx_valid/tx_data are ignored for the whole frame.
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_WIDTH-1:0]         parallel_data,
  output logic                          serial_enable,
  output logic [$clog2(DATA_WIDTH)-1:0] serial_data_index,
  output logic [1:0]                    mux_sel,
  output logic                          parity_bit,
  output logic                          busy,
  output logic                          tx_done
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_WIDTH - 1);

  uart_tx_state_t   state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q;
  logic             bit_tick;
  logic             accept;
  logic             baud_clear;

  assign tx_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign accept     = tx_valid && tx_ready;
  assign baud_clear = (state_q == IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (baud_clear),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_idx_q     <= '0;
      parallel_data <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        parallel_data <= tx_data;
        bit_idx_q     <= '0;
      end else if (state_q == DATA && bit_tick) begin
        bit_idx_q <= bit_idx_q + 1'b1;
      end
    end
  end

  // serial_enable fires one cycle early so the serializer register lines up with the bit period
  always_comb begin
    state_d           = state_q;
    serial_enable     = 1'b0;
    serial_data_index = '0;
    mux_sel           = UART_SEL_IDLE;
    tx_done           = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = START;
      end
      START: begin
        mux_sel = UART_SEL_START;
        if (bit_tick) begin
          serial_enable = 1'b1;
          state_d       = DATA;
        end
      end
      DATA: begin
        mux_sel = UART_SEL_DATA;
        if (bit_tick) begin
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            serial_enable     = 1'b1;
            serial_data_index = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        mux_sel = UART_SEL_PARITY;
        if (bit_tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) begin
          tx_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  assign parity_bit = ^parallel_data;
`else
  assign parity_bit = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed and random frames against a bit-period reference model, plus reset and idle checks.
module tb_uart_tx_controller;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (DW + 2 + PAR) * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] parallel_data;
  logic       serial_enable;
  logic [2:0] serial_data_index;
  logic [1:0] mux_sel;
  logic       parity_bit;
  logic       busy;
  logic       tx_done;

  always #5 clk = ~clk;

  uart_tx_controller #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .parallel_data    (parallel_data),
    .serial_enable    (serial_enable),
    .serial_data_index(serial_data_index),
    .mux_sel          (mux_sel),
    .parity_bit       (parity_bit),
    .busy             (busy),
    .tx_done          (tx_done)
  );

  // Stand-in serializer so the reconstructed line value exercises enable/index alignment
  logic ser_q;
  always @(posedge clk) begin
    if (reset) ser_q <= 1'b1;
    else if (serial_enable) ser_q <= parallel_data[serial_data_index];
  end

  typedef struct packed {
    logic [1:0] mux;
    logic       en;
    logic [2:0] idx;
    logic       done;
    logic       busy;
    logic       rdy;
    logic [7:0] pdata;
    logic       par;
    logic       line;
  } obs_t;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] last_byte = 8'h00;

  function automatic obs_t observe();
    obs_t o;
    o.mux   = mux_sel;
    o.en    = serial_enable;
    o.idx   = serial_enable ? serial_data_index : 3'd0;
    o.done  = tx_done;
    o.busy  = busy;
    o.rdy   = tx_ready;
    o.pdata = parallel_data;
    o.par   = parity_bit;
    case (mux_sel)
      2'd0:    o.line = 1'b1;
      2'd1:    o.line = 1'b0;
      2'd2:    o.line = ser_q;
      default: o.line = parity_bit;
    endcase
    return o;
  endfunction

  function automatic obs_t expect_idle(input logic [7:0] b);
    obs_t e;
    e       = '0;
    e.rdy   = 1'b1;
    e.pdata = b;
    e.par   = (PAR != 0) ? ^b : 1'b0;
    e.line  = 1'b1;
    return e;
  endfunction

  // Cycle k counted from START entry; period p selects start/data/parity/stop
  function automatic obs_t expect_frame(input logic [7:0] b, input int k);
    obs_t e;
    int   p;
    int   ph;
    p       = k / CPB;
    ph      = k % CPB;
    e       = '0;
    e.busy  = 1'b1;
    e.pdata = b;
    e.par   = (PAR != 0) ? ^b : 1'b0;
    if (p == 0) begin
      e.mux  = 2'd1;
      e.line = 1'b0;
    end else if (p <= DW) begin
      e.mux  = 2'd2;
      e.line = b[p-1];
    end else if (PAR != 0 && p == DW + 1) begin
      e.mux  = 2'd3;
      e.line = ^b;
    end else begin
      e.mux  = 2'd0;
      e.line = 1'b1;
    end
    e.en   = (ph == CPB - 1) && (p < DW);
    e.idx  = e.en ? 3'(p) : 3'd0;
    e.done = (k == FRAME - 1);
    return e;
  endfunction

  task automatic check(input string tag, input obs_t o, input obs_t e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit keep_valid, input logic [7:0] during);
    tx_data  = b;
    tx_valid = 1'b1;
    check($sformatf("accept_%02h", b), observe(), expect_idle(last_byte));
    step();
    last_byte = b;
    tx_valid  = keep_valid;
    tx_data   = during;
    for (int k = 0; k < FRAME; k++) begin
      check($sformatf("frame_%02h_k%0d", b, k), observe(), expect_frame(b, k));
      step();
    end
  endtask

  initial begin
    logic [7:0] rb;
    int         gap;

    reset = 1'b1;
    step();
    step();
    check("reset_state", observe(), expect_idle(8'h00));
    reset = 1'b0;
    step();
    check("post_reset_ready", observe(), expect_idle(8'h00));

    // 0xA5 with tx_data scrambled mid-frame
    send_frame(8'hA5, 1'b0, 8'hFF);
    check("idle_after_a5", observe(), expect_idle(8'hA5));
    step();

    send_frame(8'h01, 1'b0, 8'h00);

    // Back-to-back with tx_valid held: single IDLE cycle between frames
    send_frame(8'h3C, 1'b1, 8'hC3);
    send_frame(8'hC3, 1'b0, 8'h5A);

    for (int i = 0; i < 100; i++) begin
      check($sformatf("idle_%0d", i), observe(), expect_idle(last_byte));
      step();
    end

    for (int n = 0; n < 6; n++) begin
      rb  = 8'($urandom);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        check($sformatf("gap_%0d_%0d", n, g), observe(), expect_idle(last_byte));
        step();
      end
      send_frame(rb, 1'b0, 8'($urandom));
    end

    // Reset during DATA bit 3 aborts with no tx_done
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      check($sformatf("abort_k%0d", k), observe(), expect_frame(8'hA5, k));
      if (k < 17) step();
    end
    reset = 1'b1;
    step();
    last_byte = 8'h00;
    check("abort_in_reset", observe(), expect_idle(8'h00));
    reset = 1'b0;
    for (int i = 0; i < 2 * CPB * DW; i++) begin
      step();
      check($sformatf("after_abort_%0d", i), observe(), expect_idle(8'h00));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
